spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Sequences a single SPI master core (`spi`) on behalf of `N_REQ` clients. It arbitrates round-robin between clients and holds the grant for a whole multi-byte frame. It drives one chip-select per client and hands bytes to and from the master with valid/ready and done handshakes. It sits between bus-side peripheral drivers and the shared `spi` shift engine.

## Interface
- `N_REQ`, 4: number of clients / chip-selects, ≥2.
- `DATA_W`, 8: byte width exchanged with `spi`.
- `CS_GAP`, 2: minimum cycles with all `cs_n` high between frames, ≥0.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `c_valid` in N_REQ: client i has a byte to send.
- `c_last` in N_REQ: qualifies `c_valid[i]`; this byte ends the frame.
- `c_tx_data` in N_REQ*DATA_W: client i byte at slice i.
- `c_ready` out N_REQ: byte accepted when `c_valid[i]&c_ready[i]`.
- `c_rx_valid` out N_REQ: one-cycle pulse; received byte on `c_rx_data`.
- `c_rx_data` out DATA_W: shared received byte.
- `cs_n` out N_REQ: active-low chip-selects, at most one low.
- `m_start` out 1: one-cycle pulse to `spi`, starts a byte.
- `m_tx_data` out DATA_W: byte to `spi`, valid with `m_start`.
- `m_busy` in 1: `spi` shifting, cannot accept `m_start`.
- `m_done` in 1: one-cycle pulse, `m_rx_data` valid.
- `m_rx_data` in DATA_W: byte received by `spi`.

## Operation
- FSM states: IDLE, HOLD, BUSY, GAP.
- IDLE: if any `c_valid`, pick grant g by round-robin from pointer `ptr` (lowest index ≥ ptr, wrapping). Go to HOLD; `cs_n[g]`=0 from the next cycle.
- HOLD: `c_ready[g]`=!`m_busy`; all other `c_ready`=0. On handshake, register `c_tx_data[g]` into `m_tx_data`, latch `c_last[g]`, pulse `m_start` next cycle, and go to BUSY.
- BUSY: wait `m_done`. On `m_done`, register `m_rx_data` into `c_rx_data` and pulse `c_rx_valid[g]` next cycle.
  - If latched last: `cs_n[g]`=1 next cycle, `ptr`=(g+1) mod N_REQ, go to GAP (or IDLE if `CS_GAP`=0).
  - Otherwise return to HOLD with `cs_n[g]` still low.
- GAP: down-counter loaded with `CS_GAP`. All `cs_n` high. `c_valid` is ignored. Go to IDLE when the counter reaches 0.
- Grant is fixed for the frame. Other clients' `c_valid` is ignored until IDLE. A client may deassert `c_valid` in HOLD indefinitely; the frame stays open.
- Simultaneous requests in IDLE resolve by `ptr` only. `c_last` is irrelevant to arbitration.
- `m_done` outside BUSY is ignored.
- `c_rx_data` holds its last value between pulses.

## Timing
- Reset (async assert, sync deassert by the system) forces:
  - state IDLE, `ptr`=0, all `cs_n`=1;
  - `c_ready`=0, `c_rx_valid`=0, `c_rx_data`=0;
  - `m_start`=0, `m_tx_data`=0.
- Reset mid-frame: `cs_n` rises immediately and no `m_start` is issued. Any byte in flight in `spi` is abandoned.
- `c_valid` rises at cycle t in IDLE → `cs_n[g]` low at t+1 → earliest handshake t+1 → `m_start` at t+2.
- `m_done` at cycle d → `c_rx_valid[g]` at d+1. Non-last byte: HOLD at d+1, next handshake earliest d+1.
- Last byte: `cs_n[g]` high at d+1. IDLE at d+1+`CS_GAP`, and next `cs_n` low at d+2+`CS_GAP`.
- `c_ready`, `cs_n`, `m_start`, `c_rx_valid`, `c_rx_data` and `m_tx_data` are registered. `c_ready` may depend combinationally on `m_busy` only.

## Structure
- Package `spi_pkg` holds:
  - `spi_arb_state_t` enum (IDLE, HOLD, BUSY, GAP);
  - `$clog2`-based width helper for grant index and gap counter.
- Sub-module `spi_rr_pick`: combinational round-robin picker. Inputs are the request vector and `ptr`; outputs are grant index and `any`.
- Top holds the FSM, grant/`ptr`/last registers, gap counter and data muxes.

## Test plan
- Single client 1, 3-byte frame 0xA5,0x3C,0x81 (last on 3rd), model `spi` loops tx→rx after 8 cycles → `cs_n`=4'b1101 across all three bytes, three `c_rx_valid[1]` pulses with matching data, `cs_n` high for exactly 2 cycles after.
- Clients 0,2,3 request simultaneously, 1-byte frames, repeated → grant order 0,2,3,0; `ptr` wraps correctly; never two `cs_n` low.
- Client 2 mid-frame, client 0 asserts `c_valid` → client 0 `c_ready` stays 0 until client 2's last byte completes and GAP elapses.
- `m_busy` held high 5 cycles in HOLD → `c_ready[g]`=0 throughout, no `m_start`. Handshake completes the cycle after `m_busy` falls.
- `rst_n` low during BUSY → all `cs_n` high and outputs at reset values the same cycle. After release, a new request starts from `ptr`=0.
- `CS_GAP`=0 build, back-to-back frames from clients 1 then 2 → `cs_n[1]` high at d+1, `cs_n[2]` low at d+2.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI client arbiter.
package spi_pkg;

    // Arbiter FSM states: waiting for a request, frame open awaiting a byte,
    // byte shifting in the master, and the chip-select recovery gap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_BUSY = 2'd2,
        ST_GAP  = 2'd3
    } spi_arb_state_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above
// ptr_i, wrapping back to index 0.
module spi_rr_pick
    import spi_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    grant_o,
    output logic             any_o
);

    logic [IW-1:0] idx;

    // Scan offsets from the far end so the smallest offset from ptr_i wins.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_i) + k) % N_REQ);
            if (req_i[idx]) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sequencer that shares one SPI shift engine between N_REQ
// clients, holding the grant and chip-select for a whole multi-byte frame.
//
// Handshakes: a client byte moves when c_valid[i] & c_ready[i] are both high
// on a rising clock edge; c_ready only rises for the granted client while the
// frame is open and the master is not busy. m_start, c_rx_valid and m_done
// are single-cycle pulses with their data valid in the same cycle.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CS_GAP = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          c_valid,
    input  logic [N_REQ-1:0]          c_last,
    input  logic [N_REQ*DATA_W-1:0]   c_tx_data,
    output logic [N_REQ-1:0]          c_ready,
    output logic [N_REQ-1:0]          c_rx_valid,
    output logic [DATA_W-1:0]         c_rx_data,
    output logic [N_REQ-1:0]          cs_n,
    output logic                      m_start,
    output logic [DATA_W-1:0]         m_tx_data,
    input  logic                      m_busy,
    input  logic                      m_done,
    input  logic [DATA_W-1:0]         m_rx_data,
    output spi_arb_state_t            dbg_state_o
);

    localparam int GW = idx_w(N_REQ);
    localparam int CW = idx_w(CS_GAP + 1);

    spi_arb_state_t      state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic                last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0]    cs_n_q, cs_n_d;
    logic                m_start_q, m_start_d;
    logic [DATA_W-1:0]   m_tx_data_q, m_tx_data_d;
    logic [N_REQ-1:0]    rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;

    logic [GW-1:0]       pick_grant;
    logic                pick_any;
    logic [N_REQ-1:0]    gnt_oh;
    logic [DATA_W-1:0]   tx_sel;
    logic [GW-1:0]       ptr_next;
    logic                hs;

    spi_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (c_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    assign gnt_oh   = N_REQ'(1) << grant_q;
    assign tx_sel   = c_tx_data[grant_q*DATA_W +: DATA_W];
    assign ptr_next = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
    // Only the master's busy flag is allowed a combinational path to c_ready.
    assign hs       = (state_q == ST_HOLD) && c_valid[grant_q] && !m_busy;
    assign c_ready  = ((state_q == ST_HOLD) && !m_busy) ? gnt_oh : '0;

    assign cs_n        = cs_n_q;
    assign m_start     = m_start_q;
    assign m_tx_data   = m_tx_data_q;
    assign c_rx_valid  = rx_valid_q;
    assign c_rx_data   = rx_data_q;
    assign dbg_state_o = state_q;

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        cs_n_d      = cs_n_q;
        m_start_d   = 1'b0;
        m_tx_data_d = m_tx_data_q;
        rx_valid_d  = '0;
        rx_data_d   = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    cs_n_d  = ~(N_REQ'(1) << pick_grant);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hs) begin
                    m_tx_data_d = tx_sel;
                    last_d      = c_last[grant_q];
                    m_start_d   = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_done) begin
                    rx_data_d  = m_rx_data;
                    rx_valid_d = gnt_oh;
                    if (last_q) begin
                        cs_n_d = '1;
                        ptr_d  = ptr_next;
                        if (CS_GAP == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = CW'(CS_GAP);
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_GAP: begin
                // The gap spans exactly CS_GAP cycles including its first.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = '1;
            end
        endcase
    end

    // State and output registers; reset drops every chip-select at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            cs_n_q      <= '1;
            m_start_q   <= 1'b0;
            m_tx_data_q <= '0;
            rx_valid_q  <= '0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            cs_n_q      <= cs_n_d;
            m_start_q   <= m_start_d;
            m_tx_data_q <= m_tx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: arbitration table plus frame, blocking,
// stall, reset and zero-gap sequences against a loopback SPI master model.
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (CS_GAP = 2) ----------------
  logic [N-1:0]   c_valid, c_last;
  logic [N*W-1:0] c_tx_data;
  logic [N-1:0]   c_ready, c_rx_valid, cs_n;
  logic [W-1:0]   c_rx_data, m_tx_data, m_rx_data;
  logic           m_start, m_busy, m_done;
  spi_arb_state_t dbg_state;

  logic           busy_force, done_force;
  logic           mdl_busy, mdl_done;
  logic [3:0]     mdl_cnt;
  logic [W-1:0]   mdl_data;

  assign m_busy = mdl_busy | busy_force;
  assign m_done = mdl_done | done_force;

  spi_arbiter #(.N_REQ(N), .DATA_W(W), .CS_GAP(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_last(c_last), .c_tx_data(c_tx_data),
    .c_ready(c_ready), .c_rx_valid(c_rx_valid), .c_rx_data(c_rx_data),
    .cs_n(cs_n), .m_start(m_start), .m_tx_data(m_tx_data),
    .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- zero-gap DUT, driven by hand ----------------
  logic [N-1:0]   c_valid0, c_last0;
  logic [N*W-1:0] c_tx_data0;
  logic [N-1:0]   c_ready0, c_rx_valid0, cs_n0;
  logic [W-1:0]   c_rx_data0, m_tx_data0, m_rx_data0;
  logic           m_start0, m_busy0, m_done0;
  spi_arb_state_t dbg_state0;

  spi_arbiter #(.N_REQ(N), .DATA_W(W), .CS_GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid0), .c_last(c_last0), .c_tx_data(c_tx_data0),
    .c_ready(c_ready0), .c_rx_valid(c_rx_valid0), .c_rx_data(c_rx_data0),
    .cs_n(cs_n0), .m_start(m_start0), .m_tx_data(m_tx_data0),
    .m_busy(m_busy0), .m_done(m_done0), .m_rx_data(m_rx_data0),
    .dbg_state_o(dbg_state0)
  );

  // SPI master model: busy for 8 cycles after m_start, then loops tx to rx.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy  <= 1'b0;
      mdl_done  <= 1'b0;
      mdl_cnt   <= '0;
      mdl_data  <= '0;
      m_rx_data <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (m_start) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 4'd7;
        mdl_data <= m_tx_data;
      end else if (mdl_busy) begin
        if (mdl_cnt == 4'd0) begin
          mdl_busy  <= 1'b0;
          mdl_done  <= 1'b1;
          m_rx_data <= mdl_data;
        end else begin
          mdl_cnt <= mdl_cnt - 4'd1;
        end
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int multi_low = 0;
  int inv_bad = 0;
  int cs_bad = 0;
  int c0_bad = 0;
  int busy_bad = 0;
  logic mon_cs_en = 1'b0;
  logic mon_c0_en = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  logic [1:0] mon_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and chip-select invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(~cs_n) > 1) multi_low++;
      if (((dbg_state == ST_HOLD) || (dbg_state == ST_BUSY)) != ($countones(~cs_n) == 1)) inv_bad++;
      if (mon_cs_en && ((dbg_state == ST_HOLD) || (dbg_state == ST_BUSY)) && (cs_n != 4'b1101)) cs_bad++;
      if (mon_c0_en && (c_ready[0] || !cs_n[0])) c0_bad++;
      if (c_rx_valid != '0) begin
        mon_idx = '0;
        for (int i = 0; i < N; i++) if (c_rx_valid[i]) mon_idx = 2'(i);
        check("rx_valid onehot", $countones(c_rx_valid), 1);
        if (exp_q.size() == 0) begin
          check("rx unexpected", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx client/data", {mon_idx, c_rx_data}, mon_exp);
        end
      end
    end
  end

  // Offer one byte from client c and wait for it to be taken.
  task automatic send_byte(input int c, input logic [7:0] d, input logic l);
    int n;
    c_valid[c] = 1'b1;
    c_last[c]  = l;
    c_tx_data[c*W +: W] = d;
    n = 0;
    while (!c_ready[c] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("send_byte timeout", 0, 1);
    else exp_q.push_back({2'(c), d});
    tick();
    c_valid[c] = 1'b0;
  endtask

  task automatic wait_rx(input int c);
    int n;
    n = 0;
    while (!c_rx_valid[c] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_rx timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dbg_state != ST_IDLE && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_idle timeout", 0, 1);
  endtask

  // ---------------- arbitration table ----------------
  typedef struct {
    logic [3:0] mask;
    logic [7:0] base;
    logic [3:0] exp_cs;
    logic [1:0] exp_g;
    logic [7:0] exp_rx;
  } arb_vec_t;

  arb_vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_rdy;
    int n;

    // Client i offers byte base+i; expected grant follows the pointer.
    vecs[0] = '{4'b1101, 8'h10, 4'b1110, 2'd0, 8'h10};
    vecs[1] = '{4'b1101, 8'h20, 4'b1011, 2'd2, 8'h22};
    vecs[2] = '{4'b1101, 8'h30, 4'b0111, 2'd3, 8'h33};
    vecs[3] = '{4'b1101, 8'h40, 4'b1110, 2'd0, 8'h40};
    vecs[4] = '{4'b0010, 8'h50, 4'b1101, 2'd1, 8'h51};
    vecs[5] = '{4'b0001, 8'h60, 4'b1110, 2'd0, 8'h60};
    vecs[6] = '{4'b1001, 8'h70, 4'b0111, 2'd3, 8'h73};
    vecs[7] = '{4'b0110, 8'h80, 4'b1101, 2'd1, 8'h81};
    vecs[8] = '{4'b1000, 8'h90, 4'b0111, 2'd3, 8'h93};
    vecs[9] = '{4'b1111, 8'hA0, 4'b1110, 2'd0, 8'hA0};

    rst_n = 1'b0;
    c_valid = '0; c_last = '0; c_tx_data = '0;
    busy_force = 1'b0; done_force = 1'b0;
    c_valid0 = '0; c_last0 = '0; c_tx_data0 = '0;
    m_busy0 = 1'b0; m_done0 = 1'b0; m_rx_data0 = '0;

    // ---- reset values ----
    tick(); tick(); tick();
    check("reset cs_n", cs_n, 4'b1111);
    check("reset c_ready", c_ready, 4'b0000);
    check("reset c_rx_valid", c_rx_valid, 4'b0000);
    check("reset c_rx_data", c_rx_data, 8'h00);
    check("reset m_start", m_start, 1'b0);
    check("reset m_tx_data", m_tx_data, 8'h00);
    check("reset state", dbg_state, ST_IDLE);
    check("reset cs_n0", cs_n0, 4'b1111);
    rst_n = 1'b1;
    tick();

    // ---- table: simultaneous requests, pointer rotation and wrap ----
    for (int i = 0; i < 10; i++) begin
      c_last = '1;
      for (int c = 0; c < N; c++) c_tx_data[c*W +: W] = vecs[i].base + 8'(c);
      c_valid = vecs[i].mask;
      tick();
      exp_rdy = ~vecs[i].exp_cs;
      check($sformatf("tbl%0d cs_n", i), cs_n, vecs[i].exp_cs);
      check($sformatf("tbl%0d c_ready", i), c_ready, exp_rdy);
      exp_q.push_back({vecs[i].exp_g, vecs[i].exp_rx});
      tick();
      c_valid = '0;
      n = 0;
      while (c_rx_valid == '0 && n < 200) begin
        tick();
        n++;
      end
      check($sformatf("tbl%0d rx_valid", i), c_rx_valid, exp_rdy);
      check($sformatf("tbl%0d rx_data", i), c_rx_data, vecs[i].exp_rx);
      wait_idle();
    end

    // ---- m_done outside BUSY is ignored ----
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    check("stray done rx_valid", c_rx_valid, 4'b0000);
    check("stray done rx_data hold", c_rx_data, 8'hA0);
    check("stray done state", dbg_state, ST_IDLE);

    // ---- single client 1, three-byte frame ----
    mon_cs_en = 1'b1;
    c_valid[1] = 1'b1; c_last[1] = 1'b0; c_tx_data[1*W +: W] = 8'hA5;
    check("f1 cs_n at t", cs_n, 4'b1111);
    tick();
    check("f1 cs_n at t+1", cs_n, 4'b1101);
    check("f1 c_ready at t+1", c_ready, 4'b0010);
    exp_q.push_back({2'd1, 8'hA5});
    tick();
    c_valid[1] = 1'b0;
    check("f1 m_start at t+2", m_start, 1'b1);
    check("f1 m_tx_data", m_tx_data, 8'hA5);
    check("f1 state busy", dbg_state, ST_BUSY);
    send_byte(1, 8'h3C, 1'b0);
    send_byte(1, 8'h81, 1'b1);
    wait_rx(1);
    check("f1 cs_n high at d+1", cs_n, 4'b1111);
    check("f1 gap at d+1", dbg_state, ST_GAP);
    tick();
    check("f1 gap at d+2", dbg_state, ST_GAP);
    check("f1 cs_n high at d+2", cs_n, 4'b1111);
    tick();
    check("f1 idle at d+3", dbg_state, ST_IDLE);
    check("f1 rx_data holds", c_rx_data, 8'h81);
    mon_cs_en = 1'b0;
    check("f1 cs_n during frame", cs_bad, 0);

    // ---- client 2 mid-frame blocks client 0 ----
    send_byte(2, 8'h5A, 1'b0);
    c_valid[0] = 1'b1; c_last[0] = 1'b1; c_tx_data[0*W +: W] = 8'hC3;
    mon_c0_en = 1'b1;
    send_byte(2, 8'h6B, 1'b1);
    wait_rx(2);
    n = 0;
    do begin
      tick();
      n++;
    end while (cs_n[0] && n < 50);
    mon_c0_en = 1'b0;
    check("blk cycles to client0 cs", n, 3);
    check("blk client0 held off", c0_bad, 0);
    send_byte(0, 8'hC3, 1'b1);
    wait_idle();

    // ---- m_busy held in HOLD stalls the handshake ----
    busy_force = 1'b1;
    c_valid[1] = 1'b1; c_last[1] = 1'b1; c_tx_data[1*W +: W] = 8'h77;
    n = 0;
    while (cs_n[1] && n < 50) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      if (c_ready != '0 || m_start) busy_bad++;
      tick();
    end
    check("stall no ready/start", busy_bad, 0);
    check("stall still hold", dbg_state, ST_HOLD);
    busy_force = 1'b0;
    #1;
    check("stall ready after busy", c_ready, 4'b0010);
    exp_q.push_back({2'd1, 8'h77});
    tick();
    c_valid[1] = 1'b0;
    check("stall m_start", m_start, 1'b1);
    check("stall m_tx_data", m_tx_data, 8'h77);
    wait_rx(1);
    wait_idle();

    // ---- reset during BUSY ----
    send_byte(2, 8'h99, 1'b0);
    tick(); tick(); tick();
    check("rst pre cs_n", cs_n, 4'b1011);
    check("rst pre state", dbg_state, ST_BUSY);
    rst_n = 1'b0;
    #1;
    check("rst cs_n", cs_n, 4'b1111);
    check("rst m_start", m_start, 1'b0);
    check("rst m_tx_data", m_tx_data, 8'h00);
    check("rst c_rx_data", c_rx_data, 8'h00);
    check("rst c_rx_valid", c_rx_valid, 4'b0000);
    check("rst c_ready", c_ready, 4'b0000);
    check("rst state", dbg_state, ST_IDLE);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    c_last = '1;
    c_tx_data[1*W +: W] = 8'h11;
    c_tx_data[3*W +: W] = 8'h33;
    c_valid = 4'b1010;
    tick();
    check("rst after ptr0 grant", cs_n, 4'b1101);
    exp_q.push_back({2'd1, 8'h11});
    tick();
    c_valid = '0;
    wait_rx(1);
    wait_idle();

    // ---- zero-gap build: clients 1 then 2 back to back ----
    c_last0 = '1;
    c_tx_data0[1*W +: W] = 8'h11;
    c_tx_data0[2*W +: W] = 8'h22;
    c_valid0 = 4'b0110;
    tick();
    check("g0 cs_n client1", cs_n0, 4'b1101);
    tick();
    c_valid0[1] = 1'b0;
    check("g0 m_start", m_start0, 1'b1);
    check("g0 m_tx_data", m_tx_data0, 8'h11);
    tick();
    m_done0 = 1'b1;
    m_rx_data0 = 8'h5E;
    tick();
    m_done0 = 1'b0;
    check("g0 cs_n high at d+1", cs_n0, 4'b1111);
    check("g0 rx_valid at d+1", c_rx_valid0, 4'b0010);
    check("g0 rx_data", c_rx_data0, 8'h5E);
    tick();
    check("g0 cs_n client2 at d+2", cs_n0, 4'b1011);
    c_valid0 = '0;
    tick();

    // ---- final invariants ----
    check("never two cs_n low", multi_low, 0);
    check("cs_n matches state", inv_bad, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
